// File: rtl/unidade_flags_pkg.sv
// Shared flag-bit indices and ARM condition-code constants for the flags unit and the decoder.
package unidade_flags_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/unidade_flags_if.sv
// Bundle between the decoder/ALU side (master) and the flags unit (slave).
interface unidade_flags_if;
  import unidade_flags_pkg::*;

  flags_t     NovasFlags;
  logic       AtualizaFlags;
  logic [3:0] Condicao;
  logic       Salva;
  logic       Restaura;
  flags_t     Flags;
  logic       CondOK;
  logic [3:0] Ocupacao;
  logic       Cheia;
  logic       Vazia;
  logic       ErroPilha;

  modport master (
    output NovasFlags, AtualizaFlags, Condicao, Salva, Restaura,
    input  Flags, CondOK, Ocupacao, Cheia, Vazia, ErroPilha
  );

  modport slave (
    input  NovasFlags, AtualizaFlags, Condicao, Salva, Restaura,
    output Flags, CondOK, Ocupacao, Cheia, Vazia, ErroPilha
  );
endinterface

// File: rtl/unidade_flags_avaliador.sv
// Combinational ARM condition evaluator: CondOK from registered flags and the condition field.
module avaliador_condicao
  import unidade_flags_pkg::*;
(
  input  flags_t     Flags,
  input  logic [3:0] Condicao,
  output logic       CondOK
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondOK = 1'b0;
    case (cond_e'(Condicao))
      COND_EQ: CondOK = z;
      COND_NE: CondOK = !z;
      COND_CS: CondOK = c;
      COND_CC: CondOK = !c;
      COND_MI: CondOK = n;
      COND_PL: CondOK = !n;
      COND_VS: CondOK = v;
      COND_VC: CondOK = !v;
      COND_HI: CondOK = c && !z;
      COND_LS: CondOK = !c || z;
      COND_GE: CondOK = (n == v);
      COND_LT: CondOK = (n != v);
      COND_GT: CondOK = !z && (n == v);
      COND_LE: CondOK = z || (n != v);
      COND_AL: CondOK = 1'b1;
      COND_NV: CondOK = 1'b0;
      default: CondOK = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_flags.sv
// NZCV flags register with a LIFO shadow stack for exception entry/return and a sticky stack error.
// Updates land one cycle after the request; stack overflow, underflow and push/pop conflicts are dropped.
module unidade_flags
  import unidade_flags_pkg::*;
#(
  parameter int PROFUNDIDADE = 4
) (
  input logic           Clock,
  input logic           ResetN,
  unidade_flags_if.slave bus
);

  localparam int         IW     = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [3:0] PROF_W = 4'(PROFUNDIDADE);

  flags_t     flags_q, flags_d;
  logic [3:0] ocup_q, ocup_d;
  logic       erro_q, erro_d;
  flags_t     pilha_q [PROFUNDIDADE];
  flags_t     pilha_d [PROFUNDIDADE];

  logic       cheia, vazia;
  logic       push, pop, conflito;
  logic [3:0] ocup_dec;

  assign cheia    = (ocup_q == PROF_W);
  assign vazia    = (ocup_q == 4'd0);
  assign push     = bus.Salva && !bus.Restaura;
  assign pop      = bus.Restaura && !bus.Salva;
  assign conflito = bus.Salva && bus.Restaura;
  assign ocup_dec = ocup_q - 4'd1;

  always_comb begin
    flags_d = bus.AtualizaFlags ? bus.NovasFlags : flags_q;
    ocup_d  = ocup_q;
    erro_d  = erro_q;
    pilha_d = pilha_q;

    if (conflito) begin
      erro_d = 1'b1;
    end else if (push) begin
      // Push captures the pre-update flags even when a load happens the same cycle.
      if (cheia) begin
        erro_d = 1'b1;
      end else begin
        pilha_d[ocup_q[IW-1:0]] = flags_q;
        ocup_d                  = ocup_q + 4'd1;
      end
    end else if (pop) begin
      if (vazia) begin
        erro_d = 1'b1;
      end else begin
        flags_d = pilha_q[ocup_dec[IW-1:0]];
        ocup_d  = ocup_dec;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      flags_q <= '0;
      ocup_q  <= '0;
      erro_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ocup_q  <= ocup_d;
      erro_q  <= erro_d;
    end
  end

  // Entry contents are only readable below the occupancy count, so they carry no reset.
  always_ff @(posedge Clock) begin
    pilha_q <= pilha_d;
  end

  avaliador_condicao u_avaliador (
    .Flags    (flags_q),
    .Condicao (bus.Condicao),
    .CondOK   (bus.CondOK)
  );

  assign bus.Flags     = flags_q;
  assign bus.Ocupacao  = ocup_q;
  assign bus.Cheia     = cheia;
  assign bus.Vazia     = vazia;
  assign bus.ErroPilha = erro_q;

endmodule

// File: tb/tb_unidade_flags.sv
// Self-checking bench for unidade_flags: condition tables plus stack/reset sequences via a scoreboard.
module tb_unidade_flags;
  import unidade_flags_pkg::*;

  logic clk;
  logic rst_n;

  unidade_flags_if bus();

  unidade_flags #(.PROFUNDIDADE(4)) dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] flags;
    logic [3:0] ocup;
    logic       erro;
    logic       condok;
  } exp_t;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp_ok;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[64];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [3:0] nf, input logic at,
                       input logic sv, input logic rs, input logic [3:0] cd);
    rst_n             = rn;
    bus.NovasFlags    = nf;
    bus.AtualizaFlags = at;
    bus.Salva         = sv;
    bus.Restaura      = rs;
    bus.Condicao      = cd;
  endtask

  // Drive one cycle of stimulus, queue what the DUT must show after the edge, then compare.
  task automatic step(input string nm, input logic rn, input logic [3:0] nf, input logic at,
                      input logic sv, input logic rs, input logic [3:0] cd,
                      input logic [3:0] e_flags, input logic [3:0] e_ocup,
                      input logic e_erro, input logic e_ok);
    exp_t e;
    exp_t got;
    e.nm = nm; e.flags = e_flags; e.ocup = e_ocup; e.erro = e_erro; e.condok = e_ok;
    drive(rn, nf, at, sv, rs, cd);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.nm, ".flags"},  bus.Flags,    got.flags);
    chk({got.nm, ".ocup"},   bus.Ocupacao, got.ocup);
    chk({got.nm, ".erro"},   {3'b0, bus.ErroPilha}, {3'b0, got.erro});
    chk({got.nm, ".condok"}, {3'b0, bus.CondOK},    {3'b0, got.condok});
    chk({got.nm, ".cheia"},  {3'b0, bus.Cheia},     {3'b0, (got.ocup == 4'd4)});
    chk({got.nm, ".vazia"},  {3'b0, bus.Vazia},     {3'b0, (got.ocup == 4'd0)});
  endtask

  initial begin
    logic [3:0]  pats  [4];
    logic [15:0] masks [4];
    logic [15:0] m;

    pats[0] = 4'b0000; masks[0] = 16'h56AA;
    pats[1] = 4'b0100; masks[1] = 16'h66A9;
    pats[2] = 4'b1001; masks[2] = 16'h565A;
    pats[3] = 4'b0010; masks[3] = 16'h55A6;
    for (int p = 0; p < 4; p++) begin
      m = masks[p];
      for (int c = 0; c < 16; c++) begin
        vecs[p*16+c].flags  = pats[p];
        vecs[p*16+c].cond   = 4'(c);
        vecs[p*16+c].exp_ok = m[c];
      end
    end

    drive(1'b0, 4'hF, 1'b1, 1'b1, 1'b0, COND_AL);
    step("reset", 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, COND_EQ, 4'h0, 4'd0, 1'b0, 1'b0);
    step("rst_ne", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, COND_NE, 4'h0, 4'd0, 1'b0, 1'b1);
    step("rst_ge", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, COND_GE, 4'h0, 4'd0, 1'b0, 1'b1);

    // CondOK must not see NovasFlags before the edge.
    drive(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, COND_EQ);
    #1;
    chk("no_bypass", {3'b0, bus.CondOK}, 4'h0);
    step("load0100_eq", 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, COND_EQ, 4'b0100, 4'd0, 1'b0, 1'b1);
    step("load0100_ne", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, COND_NE, 4'b0100, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++) begin
      if (i % 16 == 0)
        step($sformatf("tbl_load_%h", vecs[i].flags), 1'b1, vecs[i].flags, 1'b1, 1'b0, 1'b0,
             COND_AL, vecs[i].flags, 4'd0, 1'b0, 1'b1);
      step($sformatf("tbl_f%h_c%h", vecs[i].flags, vecs[i].cond), 1'b1, 4'h0, 1'b0, 1'b0, 1'b0,
           vecs[i].cond, vecs[i].flags, 4'd0, 1'b0, vecs[i].exp_ok);
    end

    // Push pre-update flags while loading new ones, then pop them back.
    step("push_upd", 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, COND_AL, 4'b1000, 4'd1, 1'b0, 1'b1);
    step("pop_back", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, COND_AL, 4'b0010, 4'd0, 1'b0, 1'b1);

    step("fill1", 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, COND_AL, 4'b0001, 4'd1, 1'b0, 1'b1);
    step("fill2", 1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, COND_AL, 4'b0011, 4'd2, 1'b0, 1'b1);
    step("push_only", 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, COND_AL, 4'b0011, 4'd3, 1'b0, 1'b1);
    step("fill4", 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, COND_AL, 4'b0111, 4'd4, 1'b0, 1'b1);
    step("overflow", 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, COND_AL, 4'b1110, 4'd4, 1'b1, 1'b1);
    step("sticky", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, COND_AL, 4'b1110, 4'd4, 1'b1, 1'b1);
    step("pop3_ignupd", 1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, COND_AL, 4'b0011, 4'd3, 1'b1, 1'b1);
    step("pop2", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, COND_AL, 4'b0011, 4'd2, 1'b1, 1'b1);
    step("pop1", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, COND_AL, 4'b0001, 4'd1, 1'b1, 1'b1);
    step("pop0", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, COND_AL, 4'b0010, 4'd0, 1'b1, 1'b1);

    step("reset2", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, COND_AL, 4'h0, 4'd0, 1'b0, 1'b1);
    step("underflow_upd", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, COND_AL, 4'b0001, 4'd0, 1'b1, 1'b1);

    step("reset3", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, COND_AL, 4'h0, 4'd0, 1'b0, 1'b1);
    step("c_push1", 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, COND_AL, 4'b0101, 4'd1, 1'b0, 1'b1);
    step("c_push2", 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, COND_AL, 4'b0101, 4'd2, 1'b0, 1'b1);
    step("conflict", 1'b1, 4'b1100, 1'b1, 1'b1, 1'b1, COND_AL, 4'b1100, 4'd2, 1'b1, 1'b1);
    step("c_pop", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, COND_AL, 4'b0101, 4'd1, 1'b1, 1'b1);
    step("reset_ovr", 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, COND_AL, 4'h0, 4'd0, 1'b0, 1'b1);
    step("discarded", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, COND_AL, 4'h0, 4'd0, 1'b1, 1'b1);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
